// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared 7-segment pattern constants, bit order and state enum
package seg7_pkg;

    // Segment bit order inside the {none, segments} code
    localparam int SEG_A    = 0;
    localparam int SEG_G    = 6;
    localparam int SEG_NONE = 7;

    localparam logic [6:0] SEG7_DIGIT [0:7] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07
    };

    localparam logic [7:0] SEG7_BLANK = 8'h80;

    typedef enum logic [1:0] {
        BLANK = 2'd0,
        DIGIT = 2'd1,
        FAULT = 2'd2
    } seg7_state_t;

    function automatic logic [7:0] seg7_onehot(input logic [2:0] idx);
        return 8'd1 << idx;
    endfunction

endpackage

// File: rtl/seg7_index_reader_if.sv
// rtl/seg7_index_reader_if.sv - sensed pattern in, decoded digit out (err_count under SEG7_READER_ERR_COUNT_EN)
interface seg7_index_reader_if;
    logic [6:0] segments;
    logic       none;
    logic [2:0] index;
    logic [7:0] onehot;
    logic       valid;
    logic       blank;
    logic       illegal;
    logic       update;
`ifdef SEG7_READER_ERR_COUNT_EN
    logic [7:0] err_count;

    modport master (
        output segments, none,
        input  index, onehot, valid, blank, illegal, update, err_count
    );
    modport slave (
        input  segments, none,
        output index, onehot, valid, blank, illegal, update, err_count
    );
`else
    modport master (
        output segments, none,
        input  index, onehot, valid, blank, illegal, update
    );
    modport slave (
        input  segments, none,
        output index, onehot, valid, blank, illegal, update
    );
`endif
endinterface

// File: rtl/seg7_pattern_classify.sv
// rtl/seg7_pattern_classify.sv - combinational {none,segments} to {index, class} lookup
module seg7_pattern_classify
    import seg7_pkg::*;
(
    input  logic [7:0]  i_code,
    output logic [2:0]  o_index,
    output seg7_state_t o_class
);

    always_comb begin
        o_index = '0;
        o_class = FAULT;
        if (i_code == SEG7_BLANK) begin
            o_class = BLANK;
        end
        for (int i = 0; i < 8; i++) begin
            if (!i_code[SEG_NONE] && i_code[SEG_G:SEG_A] == SEG7_DIGIT[i]) begin
                o_index = 3'(i);
                o_class = DIGIT;
            end
        end
    end

endmodule

// File: rtl/seg7_index_reader.sv
// rtl/seg7_index_reader.sv - debounce a sensed 7-segment pattern and decode it to a bit index
// Optional fault-entry counter built when SEG7_READER_ERR_COUNT_EN is defined.
module seg7_index_reader
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input logic               clk,
    input logic               rst,
    seg7_index_reader_if.slave bus
);

    localparam logic [7:0] C_MAX  = 8'(STABLE_CYCLES);
    localparam logic [7:0] C_LAST = 8'(STABLE_CYCLES - 1);

    logic [7:0]  w_code;
    logic [7:0]  r_sample;
    logic [7:0]  r_cnt;
    logic        w_accept;
    logic [2:0]  w_cls_index;
    seg7_state_t w_class;

    seg7_state_t r_state, w_state_nx;
    logic [2:0]  r_index, w_index_nx;
    logic        r_update, w_update_nx;

    assign w_code = {bus.none, bus.segments};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sample <= SEG7_BLANK;
            r_cnt    <= '0;
        end else begin
            r_sample <= w_code;
            if (w_code != r_sample) begin
                r_cnt <= '0;
            end else if (r_cnt != C_MAX) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    // r_cnt counts repeats after the capture edge, so STABLE_CYCLES samples means r_cnt >= STABLE_CYCLES-1
    assign w_accept = (r_cnt >= C_LAST);

    seg7_pattern_classify u_classify (
        .i_code  (r_sample),
        .o_index (w_cls_index),
        .o_class (w_class)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= BLANK;
            r_index  <= '0;
            r_update <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_index  <= w_index_nx;
            r_update <= w_update_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_index_nx  = r_index;
        w_update_nx = 1'b0;
        if (w_accept) begin
            case (w_class)
                DIGIT: begin
                    if (r_state != DIGIT || r_index != w_cls_index) begin
                        w_state_nx  = DIGIT;
                        w_index_nx  = w_cls_index;
                        w_update_nx = 1'b1;
                    end
                end
                BLANK: begin
                    if (r_state != BLANK) begin
                        w_state_nx  = BLANK;
                        w_index_nx  = '0;
                        w_update_nx = 1'b1;
                    end
                end
                default: begin
                    if (r_state != FAULT) begin
                        w_state_nx  = FAULT;
                        w_index_nx  = '0;
                        w_update_nx = 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.index   = r_index;
    assign bus.onehot  = (r_state == DIGIT) ? seg7_onehot(r_index) : 8'h00;
    assign bus.valid   = (r_state == DIGIT);
    assign bus.blank   = (r_state == BLANK);
    assign bus.illegal = (r_state == FAULT);
    assign bus.update  = r_update;

`ifdef SEG7_READER_ERR_COUNT_EN
    logic [7:0] r_err_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_count <= '0;
        end else if (w_state_nx == FAULT && r_state != FAULT && r_err_count != 8'hFF) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign bus.err_count = r_err_count;
`endif

endmodule
